// File: rtl/mem_wait_ctrl_pkg.sv
// Shared types and helpers for the wait-stated memory controller.
// Holds the FSM state encoding, the data-region base and address helpers.
package mem_ctrl_pkg;

    localparam logic [31:0] DATA_BASE_DEF = 32'h0000_0200;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Byte address to 32-bit word number (byte-lane bits dropped).
    function automatic logic [31:0] word_idx(input logic [31:0] addr);
        return {2'b00, addr[31:2]};
    endfunction

endpackage

// File: rtl/mem_wait_ctrl_if.sv
// CPU-to-memory request/response bus.
// master = CPU side, slave = memory controller side.
interface mem_wait_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);
    logic              cpu_mem_req;
    logic              cpu_mem_we;
    logic [ADDR_W-1:0] cpu_mem_addr;
    logic [XLEN-1:0]   cpu_mem_wdata;
    logic [XLEN-1:0]   cpu_mem_rdata;
    logic              cpu_mem_ready;

    modport master (
        output cpu_mem_req,
        output cpu_mem_we,
        output cpu_mem_addr,
        output cpu_mem_wdata,
        input  cpu_mem_rdata,
        input  cpu_mem_ready
    );

    modport slave (
        input  cpu_mem_req,
        input  cpu_mem_we,
        input  cpu_mem_addr,
        input  cpu_mem_wdata,
        output cpu_mem_rdata,
        output cpu_mem_ready
    );
endinterface

// File: rtl/mem_word_array.sv
// Unreset word RAM: two write ports (load beats cpu on the same word)
// and one asynchronous read port.
module mem_word_array #(
    parameter int DEPTH_WORDS = 512,
    parameter int XLEN        = 32
) (
    input  logic                           clk,
    input  logic                           load_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx,
    input  logic [XLEN-1:0]                load_data,
    input  logic                           cpu_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] cpu_idx,
    input  logic [XLEN-1:0]                cpu_data,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [XLEN-1:0]                rd_data
);
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Writes; the load port is issued last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            mem[cpu_idx] <= cpu_data;
        end
        if (load_we) begin
            mem[load_idx] <= load_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mem_wait_ctrl.sv
// Unified instruction/data RAM controller: zero-wait instruction region,
// DATA_WAIT-cycle data region with abort detection and stall/abort counters.
module mem_wait_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          XLEN        = 32,
    parameter int          DEPTH_WORDS = 512,
    parameter logic [31:0] DATA_BASE   = DATA_BASE_DEF,
    parameter int          DATA_WAIT   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    mem_wait_ctrl_if.slave                 bus,
    input  logic                           load_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [XLEN-1:0]                load_data,
    output logic [31:0]                    stall_cycles,
    output logic [15:0]                    abort_cnt
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT =
        (DATA_WAIT > 0) ? 4'(DATA_WAIT - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic              lat_we_q, lat_we_d;
    logic [XLEN-1:0]   lat_wdata_q, lat_wdata_d;
    logic [3:0]        cnt_q, cnt_d;

    logic [31:0]       cur_word;
    logic [31:0]       lat_word;
    logic [31:0]       rd_word;
    logic              cur_is_data;
    logic              cur_in_range;
    logic              lat_in_range;
    logic              rd_in_range;
    logic              mismatch;

    logic              ready;
    logic              abort;
    logic              rd_sel_lat;
    logic              cpu_we;
    logic [IDX_W-1:0]  cpu_idx;
    logic [XLEN-1:0]   cpu_data;
    logic [XLEN-1:0]   rd_data;

    assign cur_word     = word_idx(32'(bus.cpu_mem_addr));
    assign lat_word     = word_idx(32'(lat_addr_q));
    assign cur_is_data  = 32'(bus.cpu_mem_addr) >= DATA_BASE;
    assign cur_in_range = cur_word < 32'(DEPTH_WORDS);
    assign lat_in_range = lat_word < 32'(DEPTH_WORDS);

    // A held transaction is abandoned if the CPU lets go or retargets it.
    assign mismatch = !bus.cpu_mem_req
                   || (bus.cpu_mem_addr != lat_addr_q)
                   || (bus.cpu_mem_we != lat_we_q);

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .XLEN        (XLEN)
    ) u_array (
        .clk       (clk),
        .load_we   (load_we),
        .load_idx  (load_addr),
        .load_data (load_data),
        .cpu_we    (cpu_we),
        .cpu_idx   (cpu_idx),
        .cpu_data  (cpu_data),
        .rd_idx    (rd_word[IDX_W-1:0]),
        .rd_data   (rd_data)
    );

    assign rd_word     = rd_sel_lat ? lat_word : cur_word;
    assign rd_in_range = rd_word < 32'(DEPTH_WORDS);

    assign bus.cpu_mem_ready = ready;
    assign bus.cpu_mem_rdata =
        (rst || !rd_in_range) ? '0 : rd_data;

    // FSM state and latched transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_addr_q  <= '0;
            lat_we_q    <= 1'b0;
            lat_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            lat_addr_q  <= lat_addr_d;
            lat_we_q    <= lat_we_d;
            lat_wdata_q <= lat_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next state, handshake and RAM write selection.
    always_comb begin
        state_d     = state_q;
        lat_addr_d  = lat_addr_q;
        lat_we_d    = lat_we_q;
        lat_wdata_d = lat_wdata_q;
        cnt_d       = cnt_q;
        ready       = 1'b0;
        abort       = 1'b0;
        rd_sel_lat  = 1'b0;
        cpu_we      = 1'b0;
        cpu_idx     = cur_word[IDX_W-1:0];
        cpu_data    = bus.cpu_mem_wdata;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_mem_req) begin
                    if (cur_is_data && (DATA_WAIT != 0)) begin
                        lat_addr_d  = bus.cpu_mem_addr;
                        lat_we_d    = bus.cpu_mem_we;
                        lat_wdata_d = bus.cpu_mem_wdata;
                        cnt_d       = WAIT_INIT;
                        state_d     = (DATA_WAIT == 1) ? RESP : WAIT;
                    end else begin
                        ready  = 1'b1;
                        cpu_we = bus.cpu_mem_we && cur_in_range;
                    end
                end
            end
            WAIT: begin
                if (mismatch) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rd_sel_lat = 1'b1;
                state_d    = IDLE;
                if (mismatch) begin
                    abort = 1'b1;
                end else begin
                    ready    = 1'b1;
                    cpu_we   = lat_we_q && lat_in_range;
                    cpu_idx  = lat_word[IDX_W-1:0];
                    cpu_data = lat_wdata_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset blanks the handshake and blocks any pending store.
        if (rst) begin
            ready  = 1'b0;
            cpu_we = 1'b0;
        end
    end

    // Saturating stall and abort counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            abort_cnt    <= '0;
        end else begin
            if (bus.cpu_mem_req && !ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (abort && (abort_cnt != '1)) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Randomised transaction bench for mem_wait_ctrl against a word-level
// memory model with latency, stall and abort bookkeeping.
module tb_mem_wait_ctrl;

    localparam int DW = 2;

    logic        clk;
    logic        rst;
    logic        load_we;
    logic [8:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] stall_a;
    logic [15:0] abort_a;

    logic        load_we_b;
    logic [8:0]  load_addr_b;
    logic [31:0] load_data_b;
    logic [31:0] stall_b;
    logic [15:0] abort_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [512];
    int exp_stall;
    int exp_abort;

    mem_wait_ctrl_if #(.ADDR_W(32), .XLEN(32)) ia ();
    mem_wait_ctrl_if #(.ADDR_W(32), .XLEN(32)) ib ();

    mem_wait_ctrl #(
        .ADDR_W      (32),
        .XLEN        (32),
        .DEPTH_WORDS (512),
        .DATA_BASE   (32'h200),
        .DATA_WAIT   (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (ia.slave),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .stall_cycles (stall_a),
        .abort_cnt    (abort_a)
    );

    mem_wait_ctrl #(
        .ADDR_W      (32),
        .XLEN        (32),
        .DEPTH_WORDS (512),
        .DATA_BASE   (32'h200),
        .DATA_WAIT   (0)
    ) dut_nw (
        .clk          (clk),
        .rst          (rst),
        .bus          (ib.slave),
        .load_we      (load_we_b),
        .load_addr    (load_addr_b),
        .load_data    (load_data_b),
        .stall_cycles (stall_b),
        .abort_cnt    (abort_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] addr);
        logic [31:0] w;
        w = addr >> 2;
        return (w < 512) ? mdl[w[8:0]] : 32'h0;
    endfunction

    // One CPU access; drop >= 1 releases req in that cycle (abort).
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input int drop);
        int  lat;
        int  n;
        bit  done;
        logic [31:0] w;
        lat = (addr >= 32'h200) ? DW : 0;
        w = addr >> 2;
        ia.cpu_mem_req   = 1'b1;
        ia.cpu_mem_we    = we;
        ia.cpu_mem_addr  = addr;
        ia.cpu_mem_wdata = wd;
        n = 0;
        done = 0;
        while (!done) begin
            if (n == drop) ia.cpu_mem_req = 1'b0;
            #1;
            if (n == 0) begin
                chk("stall_cnt", stall_a, 32'(exp_stall));
                chk("abort_cnt", 32'(abort_a), 32'(exp_abort));
            end
            if (n == drop) begin
                exp_stall += n;
                exp_abort++;
                done = 1;
            end else if (ia.cpu_mem_ready) begin
                chk("latency", 32'(n), 32'(lat));
                if (!we) chk("rdata", ia.cpu_mem_rdata, exp_rd(addr));
                else if (w < 512) mdl[w[8:0]] = wd;
                exp_stall += n;
                done = 1;
            end else if (n >= lat + 3) begin
                chk("timeout", 32'(n), 32'(lat));
                ia.cpu_mem_req = 1'b0;
                exp_stall += n + 1;
                done = 1;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic idle(input int cycles);
        ia.cpu_mem_req = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r < 4) a = 32'($urandom_range(0, 127)) << 2;
        else if (r < 9) a = 32'h200 + (32'($urandom_range(0, 383)) << 2);
        else a = 32'h800 + (32'($urandom_range(0, 1023)) << 2);
        return a | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] prev;
        logic        we;
        int          drop;

        rst = 1'b1;
        load_we = 1'b0;
        load_addr = '0;
        load_data = '0;
        load_we_b = 1'b0;
        load_addr_b = '0;
        load_data_b = '0;
        ia.cpu_mem_req = 1'b1;
        ia.cpu_mem_we = 1'b0;
        ia.cpu_mem_addr = '0;
        ia.cpu_mem_wdata = '0;
        ib.cpu_mem_req = 1'b0;
        ib.cpu_mem_we = 1'b0;
        ib.cpu_mem_addr = '0;
        ib.cpu_mem_wdata = '0;
        exp_stall = 0;
        exp_abort = 0;

        // Preload while reset is held.
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            load_we = 1'b1;
            load_addr = 9'(i);
            load_data = (i == 0) ? 32'h2000_0093 : $urandom;
            mdl[i] = load_data;
            @(negedge clk);
        end
        load_we = 1'b0;
        #1;
        chk("rst_ready", 32'(ia.cpu_mem_ready), 32'd0);
        chk("rst_rdata", ia.cpu_mem_rdata, 32'd0);
        chk("rst_stall", stall_a, 32'd0);
        chk("rst_abort", 32'(abort_a), 32'd0);
        @(negedge clk);
        ia.cpu_mem_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed: instruction read, data store/load, back-to-back, abort.
        access(1'b0, 32'h0, 32'h0, -1);
        access(1'b1, 32'h200, 32'h7, -1);
        access(1'b0, 32'h200, 32'h0, -1);
        access(1'b0, 32'h200, 32'h0, -1);
        access(1'b1, 32'h204, 32'hDEAD, 1);
        access(1'b0, 32'h204, 32'h0, -1);
        access(1'b1, 32'h208, 32'h1234, DW);
        access(1'b0, 32'h208, 32'h0, -1);

        // Same-word load/cpu collision: load data must survive.
        ia.cpu_mem_req = 1'b1;
        ia.cpu_mem_we = 1'b1;
        ia.cpu_mem_addr = 32'h10;
        ia.cpu_mem_wdata = 32'hAAAA_0001;
        load_we = 1'b1;
        load_addr = 9'd4;
        load_data = 32'hBBBB_0002;
        #1;
        chk("col_ready", 32'(ia.cpu_mem_ready), 32'd1);
        @(negedge clk);
        load_we = 1'b0;
        mdl[4] = 32'hBBBB_0002;
        access(1'b0, 32'h10, 32'h0, -1);

        // Reset asserted while a store waits.
        ia.cpu_mem_req = 1'b1;
        ia.cpu_mem_we = 1'b1;
        ia.cpu_mem_addr = 32'h208;
        ia.cpu_mem_wdata = 32'h5555_5555;
        @(negedge clk);
        #1;
        chk("wait_ready", 32'(ia.cpu_mem_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ia.cpu_mem_ready), 32'd0);
        chk("mid_rst_stall", stall_a, 32'd0);
        chk("mid_rst_abort", 32'(abort_a), 32'd0);
        @(negedge clk);
        ia.cpu_mem_req = 1'b0;
        rst = 1'b0;
        exp_stall = 0;
        exp_abort = 0;
        @(negedge clk);
        access(1'b0, 32'h0, 32'h0, -1);
        access(1'b0, 32'h208, 32'h0, -1);

        // Random traffic.
        prev = 32'h200;
        for (int t = 0; t < 300; t++) begin
            a = ($urandom_range(0, 5) == 0) ? prev : rand_addr();
            we = 1'($urandom_range(0, 1));
            drop = -1;
            if (a >= 32'h200 && $urandom_range(0, 4) == 0)
                drop = $urandom_range(1, DW);
            access(we, a, $urandom, drop);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            prev = a;
        end
        idle(1);
        #1;
        chk("final_stall", stall_a, 32'(exp_stall));
        chk("final_abort", 32'(abort_a), 32'(exp_abort));
        @(negedge clk);

        // Zero-wait build: data region behaves like instruction region.
        ib.cpu_mem_req = 1'b1;
        ib.cpu_mem_we = 1'b1;
        ib.cpu_mem_addr = 32'h200;
        ib.cpu_mem_wdata = 32'h0000_C0DE;
        #1;
        chk("nw_st_ready", 32'(ib.cpu_mem_ready), 32'd1);
        @(negedge clk);
        ib.cpu_mem_we = 1'b0;
        #1;
        chk("nw_ld_ready", 32'(ib.cpu_mem_ready), 32'd1);
        chk("nw_ld_rdata", ib.cpu_mem_rdata, 32'h0000_C0DE);
        @(negedge clk);
        ib.cpu_mem_addr = 32'h900;
        #1;
        chk("nw_oor_ready", 32'(ib.cpu_mem_ready), 32'd1);
        chk("nw_oor_rdata", ib.cpu_mem_rdata, 32'd0);
        @(negedge clk);
        ib.cpu_mem_req = 1'b0;
        #1;
        chk("nw_stall", stall_b, 32'd0);
        chk("nw_abort", 32'(abort_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
